// File: rtl/npc_pkg.sv
// Shared types and BTB geometry helpers for the next-PC generator.
package npc_pkg;

    // Source of the next fetch PC, reported on pc_sel.
    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BTB  = 3'd1,
        SEL_JAL  = 3'd2,
        SEL_EX   = 3'd3,
        SEL_TRAP = 3'd4,
        SEL_HOLD = 3'd5
    } npc_sel_e;

    // Index width of a direct-mapped BTB with the given depth.
    function automatic int unsigned btb_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Tag width: PC bits above the index and the 2-bit word offset.
    function automatic int unsigned btb_tag_w(input int unsigned xlen, input int unsigned entries);
        return xlen - btb_idx_w(entries) - 2;
    endfunction

    // Index field pc[idx_w+1:2], right-aligned.
    function automatic logic [63:0] btb_idx(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag field pc[XLEN-1:idx_w+2], right-aligned.
    function automatic logic [63:0] btb_tag(input logic [63:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous
// install/invalidate, synchronous active-low clear of the valid bits.
module btb_dm
    import npc_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    localparam int unsigned IDX_W = btb_idx_w(ENTRIES);
    localparam int unsigned TAG_W = btb_tag_w(XLEN, ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [TAG_W-1:0]   tag_d [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [XLEN-1:0]    tgt_d [ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;

    assign rd_idx = IDX_W'(btb_idx(64'(rd_pc), IDX_W));
    assign rd_tag = TAG_W'(btb_tag(64'(rd_pc), IDX_W));
    assign wr_idx = IDX_W'(btb_idx(64'(wr_pc), IDX_W));
    assign wr_tag = TAG_W'(btb_tag(64'(wr_pc), IDX_W));

    // Lookup reads registered state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_target = rd_hit ? tgt_q[rd_idx] : '0;
    end

    // Next-state of the arrays: install on taken, invalidate only on tag match.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (wr_en) begin
            if (wr_taken) begin
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = wr_tag;
                tgt_d[wr_idx]   = wr_target;
            end else if (tag_q[wr_idx] == wr_tag) begin
                valid_d[wr_idx] = 1'b0;
            end
        end
    end

    // Valid bits: reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target payload needs no reset; it is qualified by valid.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: rtl/npc_gen_btb.sv
// Next-PC generator: fetch PC register, fixed-priority next-PC mux and BTB.
module npc_gen_btb
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            jal,
    input  logic [XLEN-1:0] jal_target,
    input  logic            btb_upd,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic            btb_upd_taken,
    input  logic [XLEN-1:0] btb_upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output npc_sel_e        pc_sel
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] npc_raw;

    btb_dm #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (pc_q),
        .rd_hit    (pred_taken),
        .rd_target (pred_target),
        .wr_en     (btb_upd),
        .wr_pc     (btb_upd_pc),
        .wr_taken  (btb_upd_taken),
        .wr_target (btb_upd_target)
    );

    // Fixed-priority source select; trap and EX redirect override stall.
    always_comb begin
        pc_sel  = SEL_SEQ;
        npc_raw = pc_q + XLEN'(4);
        if (trap) begin
            pc_sel  = SEL_TRAP;
            npc_raw = trap_target;
        end else if (ex_redirect) begin
            pc_sel  = SEL_EX;
            npc_raw = ex_target;
        end else if (stall) begin
            pc_sel  = SEL_HOLD;
            npc_raw = pc_q;
        end else if (jal) begin
            pc_sel  = SEL_JAL;
            npc_raw = jal_target;
        end else if (pred_taken) begin
            pc_sel  = SEL_BTB;
            npc_raw = pred_target;
        end
        // Fetch is always word aligned.
        pc_d = {npc_raw[XLEN-1:2], 2'b00};
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_npc_gen_btb.sv
// Directed self-checking bench for npc_gen_btb.
module tb_npc_gen_btb;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, trap, ex_redirect, jal;
    logic        btb_upd, btb_upd_taken;
    logic [31:0] trap_target, ex_target, jal_target, btb_upd_pc, btb_upd_target;
    logic [31:0] pc, pred_target;
    logic        pred_taken;
    npc_sel_e    pc_sel;

    int errors = 0;
    int checks = 0;

    npc_gen_btb #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .trap           (trap),
        .trap_target    (trap_target),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .jal            (jal),
        .jal_target     (jal_target),
        .btb_upd        (btb_upd),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_taken  (btb_upd_taken),
        .btb_upd_target (btb_upd_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pc_sel         (pc_sel)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Force pc to addr through an EX redirect.
    task automatic goto(input logic [31:0] addr);
        ex_redirect = 1'b1;
        ex_target   = addr;
        tick();
        ex_redirect = 1'b0;
        #1;
    endtask

    // One-cycle BTB write.
    task automatic btb_write(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
        btb_upd        = 1'b1;
        btb_upd_pc     = upc;
        btb_upd_taken  = taken;
        btb_upd_target = tgt;
        tick();
        btb_upd = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst_n = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_pred: got %b/%h want 0/0", pred_taken, pred_target);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (pc_sel !== SEL_SEQ) begin
            errors++; $display("FAIL reset_sel: got %0d want %0d", pc_sel, SEL_SEQ);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 32'(4 * i);
            checks++;
            if (pc !== exp) begin
                errors++; $display("FAIL seq_%0d: got %h want %h", i, pc, exp);
            end
        end
    endtask

    task automatic test_jal();
        tick();
        checks++;
        if (pc !== 32'h10) begin
            errors++; $display("FAIL jal_start: got %h want %h", pc, 32'h10);
        end
        jal = 1'b1; jal_target = 32'h80;
        #1;
        checks++;
        if (pc_sel !== SEL_JAL) begin
            errors++; $display("FAIL jal_sel: got %0d want %0d", pc_sel, SEL_JAL);
        end
        tick();
        checks++;
        if (pc !== 32'h80) begin
            errors++; $display("FAIL jal_pc: got %h want %h", pc, 32'h80);
        end
        jal = 1'b0;
        goto(32'h10);
        jal = 1'b1; stall = 1'b1;
        #1;
        checks++;
        if (pc_sel !== SEL_HOLD) begin
            errors++; $display("FAIL stall_sel: got %0d want %0d", pc_sel, SEL_HOLD);
        end
        tick();
        checks++;
        if (pc !== 32'h10) begin
            errors++; $display("FAIL stall_pc: got %h want %h", pc, 32'h10);
        end
        jal = 1'b0; stall = 1'b0;
    endtask

    task automatic test_priority();
        trap = 1'b1; trap_target = 32'h100;
        ex_redirect = 1'b1; ex_target = 32'h200;
        jal = 1'b1; jal_target = 32'h80; stall = 1'b1;
        #1;
        checks++;
        if (pc_sel !== SEL_TRAP) begin
            errors++; $display("FAIL prio_trap_sel: got %0d want %0d", pc_sel, SEL_TRAP);
        end
        tick();
        checks++;
        if (pc !== 32'h100) begin
            errors++; $display("FAIL prio_trap_pc: got %h want %h", pc, 32'h100);
        end
        trap = 1'b0;
        #1;
        checks++;
        if (pc_sel !== SEL_EX) begin
            errors++; $display("FAIL prio_ex_sel: got %0d want %0d", pc_sel, SEL_EX);
        end
        tick();
        checks++;
        if (pc !== 32'h200) begin
            errors++; $display("FAIL prio_ex_pc: got %h want %h", pc, 32'h200);
        end
        ex_redirect = 1'b0; jal = 1'b0; stall = 1'b0;
        #1;
    endtask

    task automatic test_btb();
        btb_write(32'h20, 1'b1, 32'h400);
        goto(32'h20);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h400 || pc_sel !== SEL_BTB) begin
            errors++;
            $display("FAIL btb_hit: got %b/%h/%0d want 1/00000400/%0d",
                     pred_taken, pred_target, pc_sel, SEL_BTB);
        end
        tick();
        checks++;
        if (pc !== 32'h400) begin
            errors++; $display("FAIL btb_pc: got %h want %h", pc, 32'h400);
        end
        btb_write(32'h20, 1'b0, 32'h0);
        goto(32'h20);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            errors++;
            $display("FAIL btb_inval: got %b/%h want 0/0", pred_taken, pred_target);
        end
        // Install while looking up the same index: lookup sees old contents.
        btb_upd = 1'b1; btb_upd_pc = 32'h20; btb_upd_taken = 1'b1; btb_upd_target = 32'h400;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL btb_same_cycle: got %b want 0", pred_taken);
        end
        tick();
        btb_upd = 1'b0;
        checks++;
        if (pc !== 32'h24) begin
            errors++; $display("FAIL btb_seq_pc: got %h want %h", pc, 32'h24);
        end
    endtask

    task automatic test_alias();
        btb_write(32'h60, 1'b1, 32'h500);
        goto(32'h20);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL alias_old: got %b want 0", pred_taken);
        end
        tick();
        checks++;
        if (pc !== 32'h24) begin
            errors++; $display("FAIL alias_old_pc: got %h want %h", pc, 32'h24);
        end
        // Not-taken update with a different tag must leave the entry alone.
        btb_write(32'h20, 1'b0, 32'h0);
        goto(32'h60);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
            errors++;
            $display("FAIL alias_new: got %b/%h want 1/00000500", pred_taken, pred_target);
        end
        tick();
        checks++;
        if (pc !== 32'h500) begin
            errors++; $display("FAIL alias_pc: got %h want %h", pc, 32'h500);
        end
    endtask

    task automatic test_boundary();
        goto(32'hFFFF_FFFC);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL wrap_pred: got %b want 0", pred_taken);
        end
        tick();
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0);
        end
        goto(32'h203);
        checks++;
        if (pc !== 32'h200) begin
            errors++; $display("FAIL align_pc: got %h want %h", pc, 32'h200);
        end
        rst_n = 1'b0;
        btb_upd = 1'b1; btb_upd_pc = 32'h30; btb_upd_taken = 1'b1; btb_upd_target = 32'h700;
        tick();
        btb_upd = 1'b0;
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL rst_upd_pc: got %h want %h", pc, 32'h0);
        end
        rst_n = 1'b1;
        goto(32'h30);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL rst_upd_entry: got %b want 0", pred_taken);
        end
        goto(32'h60);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL rst_clear: got %b want 0", pred_taken);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; trap = 1'b0; ex_redirect = 1'b0; jal = 1'b0;
        btb_upd = 1'b0; btb_upd_taken = 1'b0;
        trap_target = '0; ex_target = '0; jal_target = '0;
        btb_upd_pc = '0; btb_upd_target = '0;
        test_reset();
        test_jal();
        test_priority();
        test_btb();
        test_alias();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
